// File: rtl/gb_bus_pkg.sv
// Shared types and address map for the GB bus / OAM DMA block.
package gb_bus_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned HRAM_AW    = 7;
    localparam int unsigned HRAM_DEPTH = 127;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_ARM  = 2'd1,
        DMA_RD   = 2'd2,
        DMA_WR   = 2'd3
    } dma_state_e;

    // Echo RAM page numbers (E0-FF) fold back onto work RAM (C0-DF).
    function automatic logic [7:0] dma_src_hi(input logic [7:0] v);
        return (v >= 8'hE0) ? v - 8'h20 : v;
    endfunction

endpackage

// File: rtl/gb_hram.sv
// 127-byte high RAM: synchronous write, asynchronous read, contents survive reset.
module gb_hram
    import gb_bus_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [HRAM_AW-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [HRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/gb_bus_dma.sv
// CPU bus decoder with zero-wait HRAM / FF46, waited external port and OAM DMA engine.
module gb_bus_dma
    import gb_bus_pkg::*;
#(
    parameter int unsigned DMA_LEN = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait_n,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_e  state, state_next;
    logic [7:0]  idx, idx_next;
    logic [7:0]  src_hi, src_next;
    logic [7:0]  byte_q, byte_next;
    logic        restart_q, restart_next;
    logic        ext_busy, ext_busy_next;
    logic [7:0]  dma_reg;
    logic [7:0]  rd_latch;
    logic        access_q;
    logic        mem_re_next, mem_we_next;
    logic [15:0] mem_a_next;
    logic [7:0]  mem_wdata_next;

    logic        access_c, start_c;
    logic        hram_hit_c, reg_hit_c, ext_hit_c;
    logic        ff46_wr_c, hram_we_c, ext_start_c;
    logic [7:0]  hram_rdata;

    // An access starts on its first active cycle after an idle one.
    assign access_c    = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    assign start_c     = access_c && !access_q;
    assign hram_hit_c  = (cpu_a >= HRAM_LO) && (cpu_a <= HRAM_HI);
    assign reg_hit_c   = (cpu_a == DMA_REG_ADDR);
    assign ext_hit_c   = !hram_hit_c && !reg_hit_c;
    assign ff46_wr_c   = start_c && !cpu_wr_n && reg_hit_c;
    assign hram_we_c   = start_c && !cpu_wr_n && hram_hit_c;
    assign ext_start_c = start_c && ext_hit_c && !dma_active;
    assign cpu_wait_n  = !(ext_start_c || ext_busy);

    gb_hram u_hram (
        .clk   (clk),
        .we    (hram_we_c),
        .addr  (cpu_a[HRAM_AW-1:0]),
        .wdata (cpu_dout),
        .rdata (hram_rdata)
    );

    // External reads are blanked to FFh while DMA owns the port.
    always_comb begin
        cpu_din = rd_latch;
        if (hram_hit_c) begin
            cpu_din = hram_rdata;
        end else if (reg_hit_c) begin
            cpu_din = dma_reg;
        end else if (dma_active) begin
            cpu_din = 8'hFF;
        end
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        src_next       = src_hi;
        byte_next      = byte_q;
        restart_next   = restart_q;
        ext_busy_next  = ext_busy;
        mem_re_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_a_next     = mem_a;
        mem_wdata_next = mem_wdata;

        case (state)
            DMA_IDLE: begin
                if (ff46_wr_c) begin
                    state_next   = DMA_ARM;
                    idx_next     = 8'd0;
                    src_next     = dma_src_hi(cpu_dout);
                    restart_next = 1'b0;
                end
            end
            DMA_ARM: begin
                if (ff46_wr_c) begin
                    src_next = dma_src_hi(cpu_dout);
                end
                if (!ext_busy) begin
                    state_next = DMA_RD;
                end
            end
            DMA_RD: begin
                if (ff46_wr_c) begin
                    restart_next = 1'b1;
                end
                if (mem_ready) begin
                    byte_next  = mem_rdata;
                    state_next = DMA_WR;
                end
            end
            DMA_WR: begin
                if (ff46_wr_c) begin
                    restart_next = 1'b1;
                end
                // A rebase waits for the in-flight byte to land in OAM.
                if (mem_ready) begin
                    if (restart_q || ff46_wr_c) begin
                        idx_next     = 8'd0;
                        src_next     = dma_src_hi(ff46_wr_c ? cpu_dout : dma_reg);
                        restart_next = 1'b0;
                        state_next   = DMA_RD;
                    end else if (idx == LAST_IDX) begin
                        idx_next   = 8'd0;
                        state_next = DMA_IDLE;
                    end else begin
                        idx_next   = idx + 8'd1;
                        state_next = DMA_RD;
                    end
                end
            end
            default: state_next = DMA_IDLE;
        endcase

        if (ext_start_c) begin
            ext_busy_next = 1'b1;
        end else if (ext_busy && mem_ready) begin
            ext_busy_next = 1'b0;
        end

        // Port request for the next cycle; DMA always wins while it runs.
        case (state_next)
            DMA_RD: begin
                mem_re_next = 1'b1;
                mem_a_next  = {src_next, idx_next};
            end
            DMA_WR: begin
                mem_we_next    = 1'b1;
                mem_a_next     = OAM_BASE + 16'(idx_next);
                mem_wdata_next = byte_next;
            end
            default: begin
                if (ext_start_c) begin
                    mem_re_next    = cpu_wr_n;
                    mem_we_next    = !cpu_wr_n;
                    mem_a_next     = cpu_a;
                    mem_wdata_next = cpu_dout;
                end else if (ext_busy && !mem_ready) begin
                    mem_re_next = mem_re;
                    mem_we_next = mem_we;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= DMA_IDLE;
            idx        <= 8'd0;
            src_hi     <= 8'd0;
            byte_q     <= 8'd0;
            restart_q  <= 1'b0;
            ext_busy   <= 1'b0;
            dma_reg    <= 8'h00;
            rd_latch   <= 8'hFF;
            access_q   <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= 16'h0000;
            mem_wdata  <= 8'h00;
            dma_active <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            src_hi     <= src_next;
            byte_q     <= byte_next;
            restart_q  <= restart_next;
            ext_busy   <= ext_busy_next;
            access_q   <= access_c;
            mem_re     <= mem_re_next;
            mem_we     <= mem_we_next;
            mem_a      <= mem_a_next;
            mem_wdata  <= mem_wdata_next;
            dma_active <= (state_next != DMA_IDLE);
            if (ff46_wr_c) begin
                dma_reg <= cpu_dout;
            end
            if (ext_busy && mem_ready && mem_re) begin
                rd_latch <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/gb_bus_dma.md
GB_BUS_DMA -- requirements
Module: gb_bus_dma

Interface
REQ-001 SHALL have ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cpu_a  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_mreq_n  in  1  CPU memory request
- cpu_rd_n  in  1  CPU read strobe
- cpu_wr_n  in  1  CPU write strobe
- cpu_din  out  8  read data to CPU
- cpu_wait_n  out  1  CPU wait; low stretches the access
- mem_a  out  16  external memory address
- mem_wdata  out  8  external write data
- mem_re  out  1  external read request
- mem_we  out  1  external write request
- mem_rdata  in  8  external read data, valid with mem_ready
- mem_ready  in  1  completes the current mem_re/mem_we request
- dma_active  out  1  OAM DMA in progress
REQ-002 SHALL have parameter DMA_LEN, default 160, meaning bytes per OAM DMA transfer.

Function
REQ-003 A CPU access SHALL be cpu_mreq_n=0 with cpu_rd_n=0 or cpu_wr_n=0; its start SHALL be the first such cycle after an idle cycle.
REQ-004 Decode: FF80-FFFE -> internal HRAM; FF46 -> DMA register; all other addresses -> external port.
REQ-005 HRAM and FF46 accesses SHALL complete with zero wait states: cpu_wait_n=1, and cpu_din driven combinationally from HRAM or the DMA register.
REQ-006 An external access SHALL assert mem_re or mem_we for exactly one request, held until mem_ready.
REQ-007 For an external access, cpu_wait_n SHALL be low from the start cycle until the cycle after mem_ready.
REQ-008 On mem_ready for an external read, mem_rdata SHALL be latched, and cpu_din SHALL present the latched value until the next access.
REQ-009 A write to FF46 with value V SHALL store V and start DMA with source base {V&8'hDF... V>=E0 maps to V-20h}, 00h.
REQ-010 DMA states SHALL be IDLE, ARM, RD, WR.
- IDLE -> ARM on an FF46 write.
- ARM -> RD once no CPU external request is outstanding.
- RD: mem_a=src+idx, mem_re; on mem_ready latch the byte, go to WR.
- WR: mem_a=FE00h+idx, mem_we; on mem_ready idx++; go to RD, or to IDLE when idx reaches DMA_LEN-1.
REQ-011 dma_active SHALL be 1 in ARM/RD/WR.
REQ-012 While dma_active, CPU HRAM and FF46 accesses SHALL work normally; other reads SHALL return FFh and other writes SHALL be dropped, both with zero wait and no mem_re/mem_we.
REQ-013 A write to FF46 during DMA SHALL latch the new base; the transfer SHALL restart at idx 0 after the byte in flight completes its WR.
REQ-014 The DMA byte count SHALL be 8 bits, and idx SHALL never exceed DMA_LEN-1.
REQ-015 mem_re and mem_we SHALL never both be 1.
REQ-016 A CPU access that coincides with the RD/WR owner SHALL not reach the port; the port owner SHALL be DMA whenever dma_active.

Reset
REQ-017 On reset_n=0 at a clk edge, the block SHALL:
- set state IDLE, idx 0, DMA register 00h;
- set mem_re=0, mem_we=0, latched read data FFh, cpu_wait_n=1, dma_active=0;
- abort any access or DMA mid-operation.
REQ-018 HRAM contents SHALL NOT be reset.

Structure
REQ-019 Package gb_bus_pkg SHALL hold:
- the DMA state enum;
- the constants DMA_REG_ADDR=FF46h, OAM_BASE=FE00h, HRAM_LO=FF80h, HRAM_HI=FFFEh.
REQ-020 Sub-module gb_hram SHALL be a 127x8 array with synchronous write and asynchronous read.

Verification
REQ-021 Read 0100h, mem_ready returned 3 cycles after mem_re with rdata 3Eh -> cpu_wait_n low 4 cycles; cpu_din=3Eh; exactly one mem_re.
REQ-022 Write 5Ah to FF90h, then read FF90h -> cpu_din=5Ah; cpu_wait_n never low; no mem activity.
REQ-023 Write C1h to FF46, with mem_ready always 1 -> reads C100-C19F and writes FE00-FE9F in order; dma_active falls after write FE9F; 160 reads and 160 writes total.
REQ-024 CPU read C000h during DMA -> cpu_din=FFh, zero wait; HRAM write during DMA lands.
REQ-025 Write E2h to FF46 -> source base C200h; a second FF46 write of C3h at idx 10 -> restart, and the next read is C300h.
REQ-026 Assert reset_n=0 mid-DMA at idx 50 -> next cycle dma_active=0, mem_re=mem_we=0, FF46 reads 00h.
